// File: rtl/regfile_sb_bypass.sv
// Multi-port register file with byte-enabled writes, write-to-read bypass
// and a per-register pending scoreboard with a registered pending count.
module regfile_sb_bypass #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_clr,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_ready,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int NB = DATA_W / 8;

    // Addresses outside the array, and r0 when hardwired, are never stored or tracked.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [DATA_W-1:0] mem_reg [NUM_REGS];
    logic [NUM_REGS-1:0] pend_reg, pend_next;
    logic [ADDR_W:0]     pend_cnt_reg, pend_cnt_next;

    logic              wr_ok, iss_ok, clr_do, set_do, set_new, clr_eff;
    logic              pend_at_wr, pend_at_iss;
    logic [DATA_W-1:0] wr_old, wr_merged;

    assign wr_ok       = wr_en && addr_ok(wr_addr);
    assign iss_ok      = addr_ok(iss_addr);
    assign wr_old      = wr_ok ? mem_reg[wr_addr] : '0;
    assign pend_at_wr  = wr_ok ? pend_reg[wr_addr] : 1'b0;
    assign pend_at_iss = iss_ok ? pend_reg[iss_addr] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_merge
            assign wr_merged[gi*8 +: 8] = wr_be[gi] ? wr_data[gi*8 +: 8] : wr_old[gi*8 +: 8];
        end
    endgenerate

    // A final writeback to the issue target frees it in the same cycle (WAW check).
    assign clr_do    = wr_ok && wr_clr;
    assign iss_ready = !pend_at_iss || (clr_do && (wr_addr == iss_addr));
    assign set_do    = iss_en && iss_ready && iss_ok;
    assign set_new   = set_do && !pend_at_iss;
    assign clr_eff   = clr_do && pend_at_wr && !(set_do && (iss_addr == wr_addr));

    always_comb begin
        pend_next = pend_reg;
        if (clr_do) pend_next[wr_addr] = 1'b0;
        // Set is applied last so it wins over a same-register clear.
        if (set_do) pend_next[iss_addr] = 1'b1;
        pend_cnt_next = pend_cnt_reg + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= '0;
        end else if (wr_ok) begin
            mem_reg[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg     <= '0;
            pend_cnt_reg <= '0;
        end else begin
            pend_reg     <= pend_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

    assign pend_cnt = pend_cnt_reg;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] a;
            logic              ok, hit;
            assign a   = rd_addr[gi*ADDR_W +: ADDR_W];
            assign ok  = addr_ok(a);
            assign hit = (BYPASS != 0) && wr_ok && (wr_addr == a);
            assign rd_data[gi*DATA_W +: DATA_W] = !ok ? '0 : (hit ? wr_merged : mem_reg[a]);
            assign rd_ready[gi] = !ok || (hit && wr_clr) || !pend_reg[a];
        end
    endgenerate

endmodule
